// File: rtl/radio_sched_pkg.sv
// Shared types and sizing helpers for the frame scheduler.
package radio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } sched_state_t;

  // Idle cycles the windower needs to flush its zero padding.
  function automatic int gap_cycles(input int window_size, input int ser_cyc);
    return ser_cyc * ((window_size - 32'sd1) / 32'sd2) + 32'sd1;
  endfunction

  function automatic int img_len(input int log2_img, input int ser_cyc);
    return 32'sd1 << (log2_img + $clog2(ser_cyc));
  endfunction

endpackage

// File: rtl/window_frame_sched_if.sv
// Source-side FIFO handshake plus the windower input bus.
interface window_frame_sched_if #(
  parameter int NO_SRC = 4,
  parameter int NO_CH  = 2
);
  logic [NO_SRC-1:0]            src_frame_rdy;
  logic [NO_SRC-1:0][NO_CH-1:0] src_data;
  logic [NO_SRC-1:0]            src_pop;
  logic                         win_vld_in;
  logic [NO_CH-1:0]             win_data_in;
  logic                         win_sof;
  logic                         win_eof;

  modport master (
    input  src_frame_rdy, src_data,
    output src_pop, win_vld_in, win_data_in, win_sof, win_eof
  );

  modport slave (
    output src_frame_rdy, src_data,
    input  src_pop, win_vld_in, win_data_in, win_sof, win_eof
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above 'last', wrapping modulo N.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W-1:0] cand_s;

  // Scan farthest-first so the nearest requester after 'last' overwrites and wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int k = N; k >= 1; k--) begin
      cand_s = W'((int'(last) + k) % N);
      if (req[cand_s]) begin
        gnt_idx = cand_s;
        any     = 1'b1;
      end else begin
        any     = any;
      end
    end
  end

endmodule

// File: rtl/window_frame_sched.sv
// Round-robin frame scheduler feeding one serial windower from NO_SRC sources,
// with a fixed idle gap after each frame for the windower flush.
module window_frame_sched
  import radio_sched_pkg::*;
#(
  parameter  int NO_SRC        = 4,
  parameter  int NO_CH         = 2,
  parameter  int LOG2_IMG_SIZE = 10,
  parameter  int SER_CYC       = 1,
  parameter  int WINDOW_SIZE   = 3,
  localparam int SRC_W         = $clog2(NO_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  window_frame_sched_if.master      bus,
  output logic [SRC_W-1:0]          win_src,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int IMG_LEN = img_len(LOG2_IMG_SIZE, SER_CYC);
  localparam int GAP_CYC = gap_cycles(WINDOW_SIZE, SER_CYC);
  localparam int BEAT_W  = $clog2(IMG_LEN);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(IMG_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  sched_state_t         state_r, state_s;
  logic [SRC_W-1:0]     grant_r, last_grant_r, win_src_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [GAP_W-1:0]     gap_r;
  logic [15:0]          frame_cnt_r;
  logic [NO_SRC-1:0]    pop_s;
  logic [SRC_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 win_vld_r, win_sof_r, win_eof_r;
  logic [NO_CH-1:0]     win_data_r;

  rr_arbiter #(.N(NO_SRC)) u_arb (
    .req     (bus.src_frame_rdy),
    .last    (last_grant_r),
    .gnt_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the pop is driven straight from state so data lines up next cycle.
  always_comb begin
    state_s = state_r;
    pop_s   = '0;
    case (state_r)
      IDLE: begin
        if (enable && arb_any_s) state_s = STREAM;
        else                     state_s = IDLE;
      end
      STREAM: begin
        pop_s[grant_r] = 1'b1;
        if (beat_r == BEAT_LAST) state_s = GAP;
        else                     state_s = STREAM;
      end
      GAP: begin
        if (gap_r == GAP_LAST) state_s = IDLE;
        else                   state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Grant bookkeeping, beat/gap counters and the completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= '0;
      last_grant_r <= SRC_W'(NO_SRC - 1);
      win_src_r    <= '0;
      beat_r       <= '0;
      gap_r        <= '0;
      frame_cnt_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && arb_any_s) begin
            grant_r      <= arb_idx_s;
            last_grant_r <= arb_idx_s;
            win_src_r    <= arb_idx_s;
            beat_r       <= '0;
          end
        end
        STREAM: begin
          beat_r <= beat_r + BEAT_W'(1'b1);
          gap_r  <= '0;
        end
        GAP: begin
          if (gap_r == GAP_LAST) frame_cnt_r <= frame_cnt_r + 16'd1;
          gap_r <= gap_r + GAP_W'(1'b1);
        end
        default: beat_r <= '0;
      endcase
    end
  end

  // Windower input stage: one cycle behind the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld_r  <= 1'b0;
      win_data_r <= '0;
      win_sof_r  <= 1'b0;
      win_eof_r  <= 1'b0;
    end else if (state_r == STREAM) begin
      win_vld_r  <= 1'b1;
      win_data_r <= bus.src_data[grant_r];
      win_sof_r  <= (beat_r == '0);
      win_eof_r  <= (beat_r == BEAT_LAST);
    end else begin
      win_vld_r  <= 1'b0;
      win_data_r <= '0;
      win_sof_r  <= 1'b0;
      win_eof_r  <= 1'b0;
    end
  end

  assign bus.src_pop     = pop_s;
  assign bus.win_vld_in  = win_vld_r;
  assign bus.win_data_in = win_data_r;
  assign bus.win_sof     = win_sof_r;
  assign bus.win_eof     = win_eof_r;
  assign win_src         = win_src_r;
  assign busy            = (state_r != IDLE);
  assign frame_cnt       = frame_cnt_r;

endmodule

// File: tb/tb_window_frame_sched.sv
// Randomised and directed bench for window_frame_sched against a frame-timeline model.
module tb_window_frame_sched;

  localparam int NO_SRC        = 4;
  localparam int NO_CH         = 8;
  localparam int LOG2_IMG_SIZE = 3;
  localparam int SER_CYC       = 1;
  localparam int WINDOW_SIZE   = 3;
  localparam int IMG_LEN       = 1 << (LOG2_IMG_SIZE + $clog2(SER_CYC));
  localparam int GAP_CYC       = SER_CYC * ((WINDOW_SIZE - 1) / 2) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  win_src;
  logic        busy;
  logic [15:0] frame_cnt;

  window_frame_sched_if #(.NO_SRC(NO_SRC), .NO_CH(NO_CH)) bus ();

  window_frame_sched #(
    .NO_SRC(NO_SRC), .NO_CH(NO_CH), .LOG2_IMG_SIZE(LOG2_IMG_SIZE),
    .SER_CYC(SER_CYC), .WINDOW_SIZE(WINDOW_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus.master),
    .win_src(win_src), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the grant edge (0 = idle, no frame in flight).
  int              m_t, m_grant, m_last, m_frames;
  logic            e_vld, e_sof, e_eof, after_rst;
  logic [NO_CH-1:0] e_data;
  logic [NO_SRC-1:0] e_pop;
  int              e_src;

  function automatic int rr_pick(input int last, input logic [NO_SRC-1:0] rdy);
    for (int k = 1; k <= NO_SRC; k++) begin
      if (rdy[(last + k) % NO_SRC]) return (last + k) % NO_SRC;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  prev_t;
    int  w;
    prev_t = m_t;
    if (rst) begin
      m_t = 0; m_last = NO_SRC - 1; m_grant = 0; m_frames = 0; e_src = 0;
      e_vld = 1'b0; e_data = '0; e_sof = 1'b0; e_eof = 1'b0; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      e_vld  = (prev_t >= 1 && prev_t <= IMG_LEN);
      e_data = e_vld ? bus.src_data[m_grant] : '0;
      e_sof  = (prev_t == 1);
      e_eof  = (prev_t == IMG_LEN);
      if (m_t == 0) begin
        w = rr_pick(m_last, bus.src_frame_rdy);
        if (enable && w >= 0) begin
          m_t = 1; m_grant = w; m_last = w; e_src = w;
        end
      end else if (m_t == 1 + IMG_LEN + GAP_CYC - 1) begin
        m_t = 0;
        m_frames = (m_frames + 1) % 65536;
      end else begin
        m_t++;
      end
    end
    e_pop = (m_t >= 1 && m_t <= IMG_LEN) ? NO_SRC'(1 << m_grant) : '0;
  endtask

  task automatic run_cycle(input logic [NO_SRC-1:0] rdy, input logic en, input logic r);
    @(negedge clk);
    check_eq("src_pop",   32'(bus.src_pop),     32'(e_pop));
    check_eq("win_vld",   32'(bus.win_vld_in),  32'(e_vld));
    check_eq("win_sof",   32'(bus.win_sof),     32'(e_sof));
    check_eq("win_eof",   32'(bus.win_eof),     32'(e_eof));
    check_eq("busy",      32'(busy),            32'(m_t != 0));
    check_eq("win_src",   32'(win_src),         32'(e_src));
    check_eq("frame_cnt", 32'(frame_cnt),       32'(m_frames));
    if (e_vld || after_rst) check_eq("win_data", 32'(bus.win_data_in), 32'(e_data));
    rst    = r;
    enable = en;
    // The granted source keeps its frame ready while it is being drained.
    bus.src_frame_rdy = rdy | ((m_t >= 1 && m_t <= IMG_LEN) ? NO_SRC'(1 << m_grant) : '0);
    for (int i = 0; i < NO_SRC; i++) bus.src_data[i] = NO_CH'($urandom);
    model_step();
  endtask

  task automatic run_until_t(input int target, input logic [NO_SRC-1:0] rdy);
    int n;
    n = 0;
    while (m_t != target && n < 60) begin
      run_cycle(rdy, 1'b1, 1'b0);
      n++;
    end
    check_eq("wait_beat", 32'(m_t), 32'(target));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    bus.src_frame_rdy = '0; bus.src_data = '0;
    model_step();
    repeat (3) run_cycle(4'b0000, 1'b0, 1'b1);

    // Single request, then drain.
    repeat (12) run_cycle(4'b0001, 1'b1, 1'b0);
    repeat (15) run_cycle(4'b0000, 1'b1, 1'b0);

    // All sources requesting.
    repeat (60) run_cycle(4'b1111, 1'b1, 1'b0);

    // Enable drops at beat 3; the frame still completes.
    run_until_t(4, 4'b1111);
    repeat (25) run_cycle(4'b1111, 1'b0, 1'b0);
    repeat (15) run_cycle(4'b1111, 1'b1, 1'b0);

    // Late requester joins during another source's stream.
    repeat (15) run_cycle(4'b0000, 1'b1, 1'b0);
    run_until_t(3, 4'b0010);
    repeat (30) run_cycle(4'b0110, 1'b1, 1'b0);

    // Reset at beat 4 aborts the frame.
    run_until_t(5, 4'b1111);
    run_cycle(4'b1111, 1'b1, 1'b1);
    repeat (25) run_cycle(4'b1111, 1'b1, 1'b0);

    // Lone requester served back to back.
    repeat (40) run_cycle(4'b1000, 1'b1, 1'b0);

    // Random mix of requests, enable and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      run_cycle(NO_SRC'($urandom), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
